// File: rtl/seven_segment_scan_controller.sv
// Time-multiplexed seven-segment scan controller with tear-free shadow-register loading.
// Optional build macro LEADING_ZERO_BLANK_EN blanks zero digits above the most significant nonzero digit.
module seven_segment_scan_controller #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic                    load_ready,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      4'hF:    s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
  function automatic logic lead_zero(input logic [4*NUM_DIGITS-1:0] val,
                                     input logic [IDX_W-1:0] pos);
    logic z;
    z = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      z = z & ((j < int'(pos)) || (val[4*j +: 4] == 4'h0));
    end
    return z && (pos != {IDX_W{1'b0}});
  endfunction
`endif

  logic [1:0]              state_r, state_nxt_s;
  logic [CNT_W-1:0]        cnt_r, cnt_nxt_s;
  logic [IDX_W-1:0]        idx_r, idx_nxt_s;
  logic                    boundary_s;
  logic [4*NUM_DIGITS-1:0] shadow_r, active_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r, active_dp_r;
  logic                    pending_r, pending_nxt_s;
  logic                    transfer_s, accept_s;
  logic                    load_ready_r;
  logic                    lit_s, cur_blank_s;
  logic [3:0]              cur_nib_s;
  logic [NUM_DIGITS-1:0]   an_nxt_s, an_r;
  logic [6:0]              seg_nxt_s, seg_r;
  logic                    dp_nxt_s, dp_r, frame_tick_r;

  // Scan sequencing: slot counter, digit index and the frame-boundary strobe.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = idx_r;
    boundary_s  = 1'b0;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
      idx_nxt_s   = {IDX_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_BLANK;
          cnt_nxt_s   = {CNT_W{1'b0}};
          idx_nxt_s   = {IDX_W{1'b0}};
        end
        ST_BLANK: begin
          cnt_nxt_s = cnt_r + CNT_ONE;
          if (cnt_r == BLANK_LAST) begin
            state_nxt_s = ST_ON;
          end else begin
            state_nxt_s = ST_BLANK;
          end
        end
        ST_ON: begin
          if (cnt_r == CNT_LAST) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            state_nxt_s = ST_BLANK;
            if (idx_r == IDX_LAST) begin
              idx_nxt_s  = {IDX_W{1'b0}};
              boundary_s = 1'b1;
            end else begin
              idx_nxt_s = idx_r + IDX_ONE;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          idx_nxt_s   = {IDX_W{1'b0}};
        end
      endcase
    end
  end

  // Scan state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
    end
  end

  // Handshake: a pending shadow moves to active only while idle or at a frame wrap.
  always_comb begin
    transfer_s = pending_r && ((state_r == ST_IDLE) || boundary_s);
    accept_s   = load && load_ready_r;
    if (transfer_s) begin
      pending_nxt_s = 1'b0;
    end else if (accept_s) begin
      pending_nxt_s = 1'b1;
    end else begin
      pending_nxt_s = pending_r;
    end
  end

  // Shadow and active value registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r     <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      active_r     <= {(4*NUM_DIGITS){1'b0}};
      active_dp_r  <= {NUM_DIGITS{1'b0}};
      pending_r    <= 1'b0;
      load_ready_r <= 1'b1;
    end else begin
      if (transfer_s) begin
        active_r    <= shadow_r;
        active_dp_r <= shadow_dp_r;
      end
      if (accept_s) begin
        shadow_r    <= data_in;
        shadow_dp_r <= dp_in;
      end
      pending_r    <= pending_nxt_s;
      load_ready_r <= ~pending_nxt_s;
    end
  end

  // Pin values for the current slot; gating on enable darkens the display the cycle after it drops.
  always_comb begin
    lit_s     = enable && (state_r == ST_ON);
    cur_nib_s = active_r[{idx_r, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    cur_blank_s = lead_zero(active_r, idx_r);
`else
    cur_blank_s = 1'b0;
`endif
    if (lit_s) begin
      an_nxt_s  = ~(NUM_DIGITS'(1) << idx_r);
      seg_nxt_s = cur_blank_s ? 7'h7F : hex_decode(cur_nib_s);
      dp_nxt_s  = ~active_dp_r[idx_r];
    end else begin
      an_nxt_s  = {NUM_DIGITS{1'b1}};
      seg_nxt_s = 7'h7F;
      dp_nxt_s  = 1'b1;
    end
  end

  // Registered display pins and frame strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_r         <= {NUM_DIGITS{1'b1}};
      seg_r        <= 7'h7F;
      dp_r         <= 1'b1;
      frame_tick_r <= 1'b0;
    end else begin
      an_r         <= an_nxt_s;
      seg_r        <= seg_nxt_s;
      dp_r         <= dp_nxt_s;
      frame_tick_r <= boundary_s;
    end
  end

  assign an         = an_r;
  assign seg        = seg_r;
  assign dp         = dp_r;
  assign frame_tick = frame_tick_r;
  assign load_ready = load_ready_r;

endmodule
